alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_pkg.sv | 39 +++
 rtl/muldiv_negate.sv | 12 +
 rtl/alu_muldiv.sv | 136 +++++++++++++
 tb/tb_alu_muldiv.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - shared ALU/muldiv op codes, FSM states and helpers
package alu_muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negate
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative radix-2 multiply/divide unit
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    // CALC runs WIDTH step cycles plus one terminal cycle at cnt == WIDTH
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    md_state_e        state, state_nxt;
    md_op_e           op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
    logic             neg_prod_q, neg_q_q, neg_r_q;

    logic             accept, div_in, signed_in, div_ok;
    logic [WIDTH-1:0] abs_a, abs_b, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;

    assign div_in    = md_is_div(md_op_e'(md_op));
    assign signed_in = md_is_signed(md_op_e'(md_op));
    assign accept    = in_valid & ~cancel & (state == ST_IDLE);

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg (signed_in & A[WIDTH-1]), .x (A), .y (abs_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg (signed_in & B[WIDTH-1]), .x (B), .y (abs_b));
    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .neg (neg_prod_q), .x ({acc_hi, acc_lo}), .y (prod_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quot (
        .neg (neg_q_q), .x (acc_lo), .y (quot_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .neg (neg_r_q), .x (acc_hi), .y (rem_fix));

    // One iteration of shift-add multiply and restoring divide.
    // Multiply: acc_hi accumulates, acc_lo holds the multiplier shifting out.
    // Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
    end

    // Next-state and handshake outputs; cancel overrides everything
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (accept) state_nxt = ST_CALC;
            end
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_SIGN;
            ST_SIGN: state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (cancel) state_nxt = ST_IDLE;
    end

    // State register, operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= MD_MULT;
            cnt        <= '0;
            opnd       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            neg_prod_q <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= md_op_e'(md_op);
                opnd       <= div_in ? abs_b : abs_a;
                acc_hi     <= '0;
                acc_lo     <= div_in ? abs_a : abs_b;
                cnt        <= '0;
                neg_prod_q <= ~div_in & signed_in & (A[WIDTH-1] ^ B[WIDTH-1]);
                // Divide by zero keeps the all-ones quotient unsigned
                neg_q_q    <= div_in & signed_in & (A[WIDTH-1] ^ B[WIDTH-1]) & (B != '0);
                neg_r_q    <= div_in & signed_in & A[WIDTH-1];
            end else if (state == ST_CALC && cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
                if (md_is_div(op_q)) begin
                    acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                end else begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end
            end
            if (state == ST_SIGN && state_nxt == ST_DONE) begin
                case (op_q)
                    MD_MULT, MD_MULTU: begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    default: begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard testbench for alu_muldiv
module tb_alu_muldiv;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    md_op;
    logic [W-1:0]  A, B;
    logic          in_valid, in_ready, cancel;
    logic [W-1:0]  hi, lo;
    logic          out_valid, out_ready, busy;

    int            n_pass = 0;
    int            n_total = 0;
    logic [2*W-1:0] sb[$];

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cancel    (cancel),
        .hi        (hi),
        .lo        (lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint   sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            2'b00: begin q = sa * sb_; p = q; end
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return p;
    endfunction

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit push);
        @(negedge clk);
        chk("in_ready_before_send", 64'(in_ready), 64'd1);
        md_op = op; A = a; B = b; in_valid = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        int n = 0;
        logic [2*W-1:0] e;
        logic [W-1:0] h0, l0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        if (n >= 200) return;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_result"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
        chk({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
        h0 = hi; l0 = lo;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_state"}, {hi, lo}, {h0, l0});
            chk({tag, "_hold_flags"}, {62'b0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_release"}, {61'b0, out_valid, in_ready, busy}, 64'b010);
    endtask

    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    int           seen;

    initial begin
        rst_n = 1'b0; md_op = 2'b00; A = '0; B = '0;
        in_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {61'b0, in_ready, out_valid, busy}, 64'b100);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        send(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        collect("mult_neg", 0);
        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        collect("multu_max", 0);
        send(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        collect("div_neg7_2", 0);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        collect("div_minneg", 0);
        send(2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b1);
        collect("divu_zero", 0);
        send(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 64'hFFFF_FF9C_FFFF_FFFF, 1'b1);
        collect("div_zero_neg", 0);

        send(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1);
        collect("divu_hold", 10);

        // Cancel at CALC cycle 5, then a fresh op must not see the stale result
        send(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, '0, 1'b0);
        repeat (5) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_idle", {61'b0, in_ready, out_valid, busy}, 64'b100);
        send(2'b01, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b1);
        collect("multu_after_cancel", 0);

        // cancel together with in_valid in IDLE must not accept
        @(negedge clk);
        md_op = 2'b00; A = 32'd9; B = 32'd9; in_valid = 1'b1; cancel = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; cancel = 1'b0;
        chk("cancel_beats_valid", {62'b0, busy, in_ready}, 64'b01);

        // Reset mid-CALC discards the operation
        send(2'b00, 32'd1234, 32'd5678, '0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_midcalc_flags", {61'b0, in_ready, out_valid, busy}, 64'b100);
        chk("rst_midcalc_hilo", {hi, lo}, 64'd0);
        seen = 0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("rst_no_result", 64'(seen), 64'd0);

        for (int i = 0; i < 8; i++) begin
            rop = 2'(i);
            ra  = $urandom;
            rb  = (i == 6) ? 32'd0 : (i == 7 ? 32'hFFFF_FFFF : $urandom);
            if (i == 4) rb = rb >> 20;
            send(rop, ra, rb, model(rop, ra, rb), 1'b1);
            collect($sformatf("rand%0d_op%0d", i, rop), i % 3);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
